load_data_unit: RTL and testbench
=================================

Name: load_data_unit

Overview:
- MEM-stage load path; the read-side counterpart of the store-data lane replicator.
- Accepts one load per request, issues a word-aligned read to data memory, and waits for the read response.
- Extracts and sign- or zero-extends the addressed byte or halfword, then holds the result for writeback until the pipeline takes it.
- Drives a stall while a load is outstanding.

Parameters:
- DW, 32, data width; only 32 is supported.
- OPW, 8, width of the ALU-control opcode field.

Ports:
- clk  in  1  core clock, rising edge.
- resetn  in  1  asynchronous reset, active low.
- flushM  in  1  discard any in-flight load.
- req_valid  in  1  MEM stage presents an instruction.
- alucontrolM  in  OPW  opcode; one of EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP.
- addrM  in  32  effective byte address.
- mem_req  out  1  read strobe to data memory.
- mem_addr  out  32  {addrM[31:2],2'b00}.
- mem_rdata_valid  in  1  read data present this cycle.
- mem_rdata  in  32  read word.
- resp_valid  out  1  extracted result available.
- resp_data  out  32  extended load result.
- resp_ready  in  1  writeback accepts the result.
- stall  out  1  freeze IF..MEM.
- adel  out  1  load address error (LOAD_ADEL_CHECK_EN only).
- badvaddr  out  32  faulting address (LOAD_ADEL_CHECK_EN only).

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE; resp_valid=0, resp_data=0, adel=0, badvaddr=0; mem_req=0.
- An opcode that is not a load, with req_valid=1, is ignored: no mem_req, no stall.
- FSM states: IDLE, WAIT, HOLD, DRAIN.
  - IDLE: a load with req_valid=1 and no adel drives mem_req=1 combinationally. Registered opcode, byte offset addrM[1:0] and next state=WAIT.
  - WAIT: on mem_rdata_valid, register the extracted result; resp_valid=1 next cycle; next state=HOLD.
  - HOLD: resp_valid=1. When resp_ready=1, resp_valid=0 next cycle and next state=IDLE. A new request is accepted no earlier than the cycle after leaving HOLD.
  - DRAIN: wait for mem_rdata_valid, discard the data, return to IDLE.
- Flush in WAIT -> DRAIN. Flush in HOLD -> IDLE with resp_valid cleared. Flush in IDLE suppresses mem_req. Flush in DRAIN has no effect.
- mem_rdata_valid in IDLE or HOLD is ignored. Only one read is ever outstanding.
- Minimum latency: request at cycle N, mem_rdata_valid at N+1, resp_valid at N+2.
- stall = (IDLE and mem_req) or WAIT or DRAIN or (HOLD and not resp_ready).
- Extraction, with o = registered offset:
  - LB: sign-extend mem_rdata[8*o+7 : 8*o].
  - LBU: zero-extend the same byte.
  - LH: sign-extend the halfword selected by o[1] (0 -> [15:0], 1 -> [31:16]).
  - LHU: zero-extend the same halfword.
  - LW: the whole word.
- Reset mid-operation: immediate return to IDLE. A response arriving after reset is ignored.

Optional Feature:
- Macro: LOAD_ADEL_CHECK_EN.
- Defined:
  - In IDLE, an LH/LHU with addrM[0]=1, or an LW with addrM[1:0]!=0, asserts adel for one cycle and registers badvaddr=addrM.
  - No mem_req is issued, no stall is asserted, and the state stays IDLE.
  - badvaddr holds its value until the next fault.
- Undefined:
  - adel=0 and badvaddr=0 constantly.
  - Misaligned loads proceed: LW ignores addr[1:0]; LH/LHU use addr[1] only.

Decomposition:
- EXE_*_OP load opcodes and the 2-bit FSM state encodings live in the shared defines package.
- One natural sub-module, load_extend: purely combinational (opcode, offset, word) -> extended result, instanced once in WAIT capture.

Test Plan:
- LB, addrM=0x1003, mem_rdata=0x80AA55CC at N+1 -> resp_data=0xFFFFFF80 at N+2; stall high at N and N+1.
- LHU, addrM=0x2002, rdata=0xBEEF1234 -> resp_data=0x0000BEEF. LH with the same inputs -> 0xFFFFBEEF.
- LW, addrM=0x3000, rdata arrives 3 cycles late, resp_ready held 0 for 2 cycles:
  - resp_data=0x12345678 stays stable in HOLD;
  - stall drops in the cycle resp_ready=1.
- flushM in WAIT, then rdata=0xDEADBEEF -> no resp_valid, state returns to IDLE; a subsequent LBU at 0x10 with rdata=0x000000FF -> 0x000000FF.
- LOAD_ADEL_CHECK_EN, LW at addrM=0x4002 -> adel pulse, badvaddr=0x00004002, mem_req=0, stall=0. Without the macro -> mem_addr=0x4000 and a normal result.
- resetn pulsed low during WAIT -> all outputs 0 at once; a late mem_rdata_valid is ignored.

Source files
------------

// File: rtl/load_data_unit_pkg.sv
// Shared defines for the MEM-stage load path: load opcodes, FSM state codes, helpers.
package load_data_unit_pkg;

   localparam int LOAD_OPW = 8;

   localparam logic [LOAD_OPW-1:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [LOAD_OPW-1:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [LOAD_OPW-1:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [LOAD_OPW-1:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [LOAD_OPW-1:0] EXE_LHU_OP = 8'b1110_0101;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   function automatic logic isLoadOp(input logic [LOAD_OPW-1:0] op);
      return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
             (op == EXE_LHU_OP) || (op == EXE_LW_OP);
   endfunction

   // Halfword and word loads whose address is not naturally aligned.
   function automatic logic isMisaligned(input logic [LOAD_OPW-1:0] op, input logic [1:0] off);
      return (((op == EXE_LH_OP) || (op == EXE_LHU_OP)) && off[0]) ||
             ((op == EXE_LW_OP) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/load_data_unit_extend.sv
// Combinational byte/halfword lane select with sign or zero extension.
module load_extend
   import load_data_unit_pkg::*;
#(
   parameter int OPW = LOAD_OPW
) (
   input  logic [OPW-1:0] opcode,
   input  logic [1:0]     offset,
   input  logic [31:0]    word,
   output logic [31:0]    result
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   always_comb begin
      byteSel = word[7:0];
      case (offset)
         2'd0: byteSel = word[7:0];
         2'd1: byteSel = word[15:8];
         2'd2: byteSel = word[23:16];
         2'd3: byteSel = word[31:24];
         default: byteSel = word[7:0];
      endcase
      // Only offset[1] picks the halfword, so unaligned LH/LHU degrade gracefully.
      halfSel = offset[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      result = word;
      case (opcode)
         EXE_LB_OP:  result = {{24{byteSel[7]}}, byteSel};
         EXE_LBU_OP: result = {24'h0, byteSel};
         EXE_LH_OP:  result = {{16{halfSel[15]}}, halfSel};
         EXE_LHU_OP: result = {16'h0, halfSel};
         default:    result = word;
      endcase
   end

endmodule

// File: rtl/load_data_unit.sv
// MEM-stage load unit: one outstanding word read, extract/extend, hold until writeback.
// Optional alignment trap enabled by defining LOAD_ADEL_CHECK_EN.
//
// state | meaning
// IDLE  | no load in flight; accepts a new request
// WAIT  | read issued, waiting for mem_rdata_valid
// HOLD  | result valid, waiting for resp_ready
// DRAIN | flushed while waiting; swallow the pending read data
module load_data_unit
   import load_data_unit_pkg::*;
#(
   parameter int DW  = 32,
   parameter int OPW = 8
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           flushM,
   input  logic           req_valid,
   input  logic [OPW-1:0] alucontrolM,
   input  logic [31:0]    addrM,
   output logic           mem_req,
   output logic [31:0]    mem_addr,
   input  logic           mem_rdata_valid,
   input  logic [DW-1:0]  mem_rdata,
   output logic           resp_valid,
   output logic [DW-1:0]  resp_data,
   input  logic           resp_ready,
   output logic           stall,
   output logic           adel,
   output logic [31:0]    badvaddr
);

   logic [1:0]     state;
   logic [OPW-1:0] opReg;
   logic [1:0]     offReg;
   logic [DW-1:0]  extResult;
   logic           isLoad;
   logic           misalign;
   logic           accept;

   assign isLoad = isLoadOp(alucontrolM);

`ifdef LOAD_ADEL_CHECK_EN
   assign misalign = isMisaligned(alucontrolM, addrM[1:0]);
`else
   assign misalign = 1'b0;
`endif

   assign accept   = (state == ST_IDLE) && req_valid && isLoad && !flushM && !misalign;
   assign mem_req  = accept;
   assign mem_addr = {addrM[31:2], 2'b00};

   assign stall = accept || (state == ST_WAIT) || (state == ST_DRAIN) ||
                  ((state == ST_HOLD) && !resp_ready);

   load_extend #(.OPW(OPW)) u_extend (
      .opcode (opReg),
      .offset (offReg),
      .word   (mem_rdata),
      .result (extResult)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         opReg      <= '0;
         offReg     <= 2'b00;
         resp_valid <= 1'b0;
         resp_data  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  opReg  <= alucontrolM;
                  offReg <= addrM[1:0];
                  state  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // Data landing in the flush cycle retires the read, so skip DRAIN.
               if (flushM) begin
                  state <= mem_rdata_valid ? ST_IDLE : ST_DRAIN;
               end else if (mem_rdata_valid) begin
                  resp_data  <= extResult;
                  resp_valid <= 1'b1;
                  state      <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (flushM || resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (mem_rdata_valid) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef LOAD_ADEL_CHECK_EN
   logic adelHit;
   assign adelHit = (state == ST_IDLE) && req_valid && isLoad && !flushM && misalign;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         adel     <= 1'b0;
         badvaddr <= '0;
      end else begin
         adel <= adelHit;
         if (adelHit) badvaddr <= addrM;
      end
   end
`else
   assign adel     = 1'b0;
   assign badvaddr = '0;
`endif

endmodule

// File: tb/tb_load_data_unit.sv
// Directed self-checking bench for load_data_unit.
module tb_load_data_unit;
   import load_data_unit_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        flushM = 1'b0;
   logic        req_valid = 1'b0;
   logic [7:0]  alucontrolM = 8'h00;
   logic [31:0] addrM = 32'h0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_rdata_valid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_ready = 1'b0;
   logic        stall;
   logic        adel;
   logic [31:0] badvaddr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_data_unit #(.DW(32), .OPW(8)) dut (
      .clk(clk), .resetn(resetn), .flushM(flushM), .req_valid(req_valid),
      .alucontrolM(alucontrolM), .addrM(addrM), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
      .resp_data(resp_data), .resp_ready(resp_ready), .stall(stall), .adel(adel),
      .badvaddr(badvaddr)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0; flushM = 1'b0; mem_rdata_valid = 1'b0; resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2 resetn = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
      checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 00000000", resp_data); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
      checks++; if (adel !== 1'b0 || badvaddr !== 32'h0) begin errors++; $display("FAIL reset_adel: got %b/%h expected 0/00000000", adel, badvaddr); end
      step(); step();
      resetn = 1'b1;
      step();
   endtask

   task automatic test_non_load();
      req_valid = 1'b1; alucontrolM = 8'h21; addrM = 32'h0000_1000;
      #1;
      checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL nonload: got req=%b stall=%b expected 0/0", mem_req, stall); end
      step(); idle_inputs();
      step();
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL nonload_resp: got %b expected 0", resp_valid); end
   endtask

   task automatic test_lb();
      req_valid = 1'b1; alucontrolM = EXE_LB_OP; addrM = 32'h0000_1003;
      #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL lb_mem_req: got %b expected 1", mem_req); end
      checks++; if (mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL lb_mem_addr: got %h expected 00001000", mem_addr); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lb_stall_n: got %b expected 1", stall); end
      step();
      req_valid = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'h80AA_55CC;
      #1;
      checks++; if (stall !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL lb_n1: got stall=%b rv=%b expected 1/0", stall, resp_valid); end
      step();
      mem_rdata_valid = 1'b0; resp_ready = 1'b1;
      #1;
      checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_n2: got rv=%b data=%h expected 1/ffffff80", resp_valid, resp_data); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lb_stall_n2: got %b expected 0", stall); end
      step();
      resp_ready = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL lb_release: got %b expected 0", resp_valid); end
   endtask

   task automatic test_extract();
      logic [7:0]  ops [7];
      logic [31:0] addrs [7];
      logic [31:0] words [7];
      logic [31:0] exps [7];
      ops = '{EXE_LHU_OP, EXE_LH_OP, EXE_LBU_OP, EXE_LB_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LH_OP};
      addrs = '{32'h2002, 32'h2002, 32'h1001, 32'h1002, 32'h2000, 32'h2000, 32'h2000};
      words = '{32'hBEEF1234, 32'hBEEF1234, 32'h80AA55CC, 32'h80AA55CC, 32'h80AA55CC, 32'h00008001, 32'h00008001};
      exps = '{32'h0000BEEF, 32'hFFFFBEEF, 32'h00000055, 32'hFFFFFFAA, 32'h000055CC, 32'h00008001, 32'hFFFF8001};
      for (int i = 0; i < 7; i++) begin
         step();
         req_valid = 1'b1; alucontrolM = ops[i]; addrM = addrs[i];
         step();
         req_valid = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = words[i];
         step();
         mem_rdata_valid = 1'b0; resp_ready = 1'b1;
         #1;
         checks++; if (resp_valid !== 1'b1 || resp_data !== exps[i]) begin errors++; $display("FAIL extract_%0d: got rv=%b data=%h expected 1/%h", i, resp_valid, resp_data, exps[i]); end
         step();
         resp_ready = 1'b0;
      end
   endtask

   task automatic test_lw_slow();
      step();
      req_valid = 1'b1; alucontrolM = EXE_LW_OP; addrM = 32'h0000_3000;
      #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h3000) begin errors++; $display("FAIL lw_req: got %b/%h expected 1/00003000", mem_req, mem_addr); end
      for (int i = 0; i < 3; i++) begin
         step();
         req_valid = 1'b0;
         #1;
         checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL lw_wait_%0d: got stall=%b req=%b expected 1/0", i, stall, mem_req); end
      end
      step();
      mem_rdata_valid = 1'b1; mem_rdata = 32'h1234_5678;
      step();
      mem_rdata_valid = 1'b0; resp_ready = 1'b0;
      req_valid = 1'b1; alucontrolM = EXE_LW_OP; addrM = 32'h0000_7000;
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lw_hold_no_req: got %b expected 0", mem_req); end
      checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h1234_5678 || stall !== 1'b1) begin errors++; $display("FAIL lw_hold0: got rv=%b data=%h stall=%b expected 1/12345678/1", resp_valid, resp_data, stall); end
      step();
      req_valid = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h1234_5678 || stall !== 1'b1) begin errors++; $display("FAIL lw_hold1: got rv=%b data=%h stall=%b expected 1/12345678/1", resp_valid, resp_data, stall); end
      step();
      resp_ready = 1'b1;
      #1;
      checks++; if (stall !== 1'b0 || resp_data !== 32'h1234_5678) begin errors++; $display("FAIL lw_ready: got stall=%b data=%h expected 0/12345678", stall, resp_data); end
      step();
      resp_ready = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL lw_done: got rv=%b stall=%b expected 0/0", resp_valid, stall); end
   endtask

   task automatic test_flush();
      step();
      req_valid = 1'b1; alucontrolM = EXE_LW_OP; addrM = 32'h0000_0500;
      step();
      req_valid = 1'b0; flushM = 1'b1;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_wait_stall: got %b expected 1", stall); end
      step();
      flushM = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      #1;
      checks++; if (stall !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL flush_drain: got stall=%b rv=%b expected 1/0", stall, resp_valid); end
      step();
      mem_rdata_valid = 1'b0;
      #1;
      checks++; if (stall !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL flush_idle: got stall=%b rv=%b expected 0/0", stall, resp_valid); end
      req_valid = 1'b1; alucontrolM = EXE_LBU_OP; addrM = 32'h0000_0010;
      #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("FAIL flush_next_req: got %b/%h expected 1/00000010", mem_req, mem_addr); end
      step();
      req_valid = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'h0000_00FF;
      step();
      mem_rdata_valid = 1'b0; resp_ready = 1'b1;
      #1;
      checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h0000_00FF) begin errors++; $display("FAIL flush_lbu: got rv=%b data=%h expected 1/000000ff", resp_valid, resp_data); end
      step();
      resp_ready = 1'b0;
      req_valid = 1'b1; flushM = 1'b1; alucontrolM = EXE_LW_OP; addrM = 32'h0000_0800;
      #1;
      checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL flush_idle_req: got req=%b stall=%b expected 0/0", mem_req, stall); end
      step();
      req_valid = 1'b0; flushM = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'h5555_5555;
      step();
      mem_rdata_valid = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL stray_rdata: got rv=%b stall=%b expected 0/0", resp_valid, stall); end
   endtask

   task automatic test_misalign();
      step();
      req_valid = 1'b1; alucontrolM = EXE_LW_OP; addrM = 32'h0000_4002;
      #1;
`ifdef LOAD_ADEL_CHECK_EN
      checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL adel_req: got req=%b stall=%b expected 0/0", mem_req, stall); end
      step();
      req_valid = 1'b0;
      #1;
      checks++; if (adel !== 1'b1 || badvaddr !== 32'h0000_4002) begin errors++; $display("FAIL adel_pulse: got %b/%h expected 1/00004002", adel, badvaddr); end
      step();
      #1;
      checks++; if (adel !== 1'b0 || badvaddr !== 32'h0000_4002 || stall !== 1'b0) begin errors++; $display("FAIL adel_after: got %b/%h stall=%b expected 0/00004002/0", adel, badvaddr, stall); end
`else
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_4000) begin errors++; $display("FAIL mis_lw_req: got %b/%h expected 1/00004000", mem_req, mem_addr); end
      step();
      req_valid = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      step();
      mem_rdata_valid = 1'b0; resp_ready = 1'b1;
      #1;
      checks++; if (resp_data !== 32'hCAFE_F00D || adel !== 1'b0) begin errors++; $display("FAIL mis_lw_data: got %h adel=%b expected cafef00d/0", resp_data, adel); end
      step();
      resp_ready = 1'b0;
      req_valid = 1'b1; alucontrolM = EXE_LH_OP; addrM = 32'h0000_4003;
      step();
      req_valid = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'h8000_1111;
      step();
      mem_rdata_valid = 1'b0; resp_ready = 1'b1;
      #1;
      checks++; if (resp_data !== 32'hFFFF_8000 || badvaddr !== 32'h0) begin errors++; $display("FAIL mis_lh_data: got %h bad=%h expected ffff8000/00000000", resp_data, badvaddr); end
      step();
      resp_ready = 1'b0;
`endif
   endtask

   task automatic test_reset_mid();
      step();
      req_valid = 1'b1; alucontrolM = EXE_LW_OP; addrM = 32'h0000_0600;
      step();
      req_valid = 1'b0;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rmid_wait: got %b expected 1", stall); end
      resetn = 1'b0;
      #1;
      checks++; if (stall !== 1'b0 || resp_valid !== 1'b0 || mem_req !== 1'b0 || resp_data !== 32'h0) begin errors++; $display("FAIL rmid_clear: got stall=%b rv=%b req=%b data=%h expected 0/0/0/0", stall, resp_valid, mem_req, resp_data); end
      step();
      resetn = 1'b1;
      step();
      mem_rdata_valid = 1'b1; mem_rdata = 32'h7777_7777;
      step();
      mem_rdata_valid = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0 || stall !== 1'b0 || resp_data !== 32'h0) begin errors++; $display("FAIL rmid_late: got rv=%b stall=%b data=%h expected 0/0/0", resp_valid, stall, resp_data); end
   endtask

   initial begin
      test_reset();
      test_non_load();
      step();
      test_lb();
      test_extract();
      test_lw_slow();
      test_flush();
      test_misalign();
      test_reset_mid();
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
